// File: rtl/bla_sub_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : bla_sub_serial_if
// Description : Operand/result handshake bundle for the slice-serial
//               borrow-lookahead subtractor. The master drives operands and
//               accepts results; the slave is the subtractor itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface bla_sub_serial_if #(
  parameter int WIDTH = 16
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );
endinterface
`default_nettype wire

// File: rtl/bla_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : bla_sub_serial
// Description : Slice-serial subtractor, diff = a - b - bin over WIDTH bits,
//               resolving SLICE bits per clock with borrow lookahead inside
//               each slice (g = ~a & b, p = ~(a ^ b)). Valid/ready on both
//               the operand and the result side.
//               Optional feature macro: SUB_SAT_EN -- when defined, an
//               unsigned underflow clamps diff to 0 (zero=1, bout still 1).
// Revision    : 1.0 - initial release
// ============================================================================
module bla_sub_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bla_sub_serial_if.slave bus
);

  localparam int c_NSLICE = WIDTH / SLICE;
  localparam int c_CW     = (c_NSLICE > 1) ? $clog2(c_NSLICE) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NSLICE - 1);

  // Operands must split into whole slices
  generate
    if (((WIDTH % SLICE) != 0) || (WIDTH < SLICE)) begin : g_bad_slice
      $error("bla_sub_serial: WIDTH must be a non-zero integer multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Working registers: operands shift right one slice per BUSY cycle so the
  // current slice always sits in the low SLICE bits.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_brw;
  logic [WIDTH-1:0] r_acc;
  logic [c_CW-1:0]  r_cnt;

  // Delivered result, only written when the last slice resolves so that a
  // partial difference is never visible on the outputs.
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_zero;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;

  logic [SLICE-1:0] w_as;
  logic [SLICE-1:0] w_bs;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE:0]   w_bc;
  logic [SLICE-1:0] w_ds;
  logic             w_term;
  logic             w_pp;
  logic             w_bo;

  logic [WIDTH+SLICE-1:0] w_cat;
  logic [WIDTH-1:0]       w_acc_nxt;
  logic [WIDTH-1:0]       w_fin;

  assign w_as   = r_a[SLICE-1:0];
  assign w_bs   = r_b[SLICE-1:0];
  assign w_last = (r_cnt == c_LAST);

  // Slice borrow lookahead: each internal borrow is a flat OR of generate
  // terms qualified by the propagate run above them, plus the slice borrow-in.
  always_comb begin
    w_g    = ~w_as & w_bs;
    w_p    = ~(w_as ^ w_bs);
    w_bc   = '0;
    w_term = 1'b0;
    w_pp   = 1'b0;
    w_bc[0] = r_brw;
    for (int i = 0; i < SLICE; i++) begin
      w_term = w_g[i];
      w_pp   = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_term = w_term | (w_pp & w_g[j]);
        w_pp   = w_pp & w_p[j];
      end
      w_bc[i+1] = w_term | (w_pp & r_brw);
    end
    w_ds = w_as ^ w_bs ^ w_bc[SLICE-1:0];
  end

  assign w_bo = w_bc[SLICE];

  // New slice enters at the top of the accumulator; after NSLICE shifts the
  // whole difference is aligned at bit 0.
  assign w_cat     = {w_ds, r_acc};
  assign w_acc_nxt = w_cat[WIDTH+SLICE-1:SLICE];

`ifdef SUB_SAT_EN
  assign w_fin = w_bo ? '0 : w_acc_nxt;
`else
  assign w_fin = w_acc_nxt;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept = w_in_ready & bus.in_valid;

  // Operand capture, per-slice resolution and final result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_brw  <= 1'b0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_brw <= bus.bin;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_a   <= r_a >> SLICE;
      r_b   <= r_b >> SLICE;
      r_brw <= w_bo;
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff <= w_fin;
        r_bout <= w_bo;
        r_zero <= (w_fin == '0);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.diff      = r_diff;
  assign bus.bout      = r_bout;
  assign bus.zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_bla_sub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_bla_sub_serial
// Description : Directed self-checking bench for bla_sub_serial
//               (WIDTH=16, SLICE=4). Expected values are hand-computed;
//               SUB_SAT_EN selects the clamped expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bla_sub_serial;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   lat;

  bla_sub_serial_if #(.WIDTH(16)) bus ();

  bla_sub_serial #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SUB_SAT_EN
  localparam logic [15:0] c_UF_DIFF = 16'h0000;
  localparam logic        c_UF_ZERO = 1'b1;
`else
  localparam logic [15:0] c_UF_DIFF = 16'hFFFF;
  localparam logic        c_UF_ZERO = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then scramble the inputs
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb;
    bus.bin      = tbin;
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.bin      = 1'($urandom);
  endtask

  // Cycles counted from the accepting edge (the accept cycle is cycle 1)
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (!bus.out_valid && cycles < 40) begin
      step();
      cycles++;
    end
    chk("out_valid_reached", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic expect_res(input string tag, input logic [15:0] d, input logic bo, input logic z);
    chk({tag, "_diff"}, {16'd0, bus.diff}, {16'd0, d});
    chk({tag, "_bout"}, {31'd0, bus.bout}, {31'd0, bo});
    chk({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, z});
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tbin, input logic [15:0] d, input logic bo, input logic z);
    issue(ta, tb, tbin);
    wait_done(lat);
    expect_res(tag, d, bo, z);
    drain();
  endtask

  initial begin
    n_chk         = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 16'h0;
    bus.b         = 16'h0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_diff", {16'd0, bus.diff}, 32'd0);
    chk("rst_bout", {31'd0, bus.bout}, 32'd0);
    chk("rst_zero", {31'd0, bus.zero}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: basic subtract with latency check
    issue(16'h1234, 16'h0234, 1'b0);
    wait_done(lat);
    chk("t1_latency", lat, 32'd5);
    expect_res("t1", 16'h1000, 1'b0, 1'b0);
    drain();

    // 2: borrow ripples through three slices
    run_op("t2", 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0);
    // 3: unsigned underflow
    run_op("t3", 16'h0000, 16'h0001, 1'b0, c_UF_DIFF, 1'b1, c_UF_ZERO);
    // 4: borrow-in causes underflow, then exact zero
    run_op("t4a", 16'h0005, 16'h0005, 1'b1, c_UF_DIFF, 1'b1, c_UF_ZERO);
    run_op("t4b", 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1);
    // Extra patterns: borrow-in without underflow, lookahead across all slices
    run_op("x1", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("x2", 16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1);
    run_op("x3", 16'hA5C3, 16'h5A3C, 1'b0, 16'h4B87, 1'b0, 1'b0);

    // 5: result held in DONE while new operands are offered
    issue(16'h00F0, 16'h000F, 1'b0);
    wait_done(lat);
    bus.in_valid = 1'b1;
    bus.a        = 16'hAAAA;
    bus.b        = 16'h1111;
    bus.bin      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t5_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      expect_res("t5_hold", 16'h00E1, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t5_released", {31'd0, bus.out_valid}, 32'd0);
    chk("t5_idle_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("t5_accepted", {31'd0, bus.in_ready}, 32'd0);
    wait_done(lat);
    chk("t5_latency", lat, 32'd5);
    expect_res("t5_next", 16'h9999, 1'b0, 1'b0);
    drain();

    // 6: reset during the second BUSY cycle discards the operation
    issue(16'h4321, 16'h1111, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("t6_diff", {16'd0, bus.diff}, 32'd0);
    chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t6_no_result", {31'd0, bus.out_valid}, 32'd0);
    end
    chk("t6_ready_after", {31'd0, bus.in_ready}, 32'd1);
    run_op("t6_new", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
